mem_sequencer: RTL and testbench

- Front-panel controller for the 64x16 single-port scratch memory: async read, write on posedge clk when write and step are both high.
- Turns one-cycle step pulses from the debounced push-button into single write or read operations with address auto-increment.
- Runs two autonomous sweeps: CLEAR, which zero-fills all locations, and SUM, which produces a 16-bit wrap-around checksum.
- Sits between the switch/button front end and the memory; this block is the only driver of the memory's address, din, write and step.

---
 rtl/mem_seq_pkg.sv | 22 ++
 rtl/sweep_counter.sv | 29 ++
 rtl/mem_sequencer.sv | 148 ++++++++++++++
 tb/tb_mem_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared command codes, state encoding and default widths for the
// front-panel memory sequencer.
package mem_seq_pkg;

  localparam int unsigned AW_DEF = 6;
  localparam int unsigned DW_DEF = 16;

  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_CLEAR = 2'b10;
  localparam logic [1:0] CMD_SUM   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_SUM   = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/sweep_counter.sv
// Address sweep counter shared by the CLEAR and SUM passes; o_last_c flags
// the final location so the controller can finish on that cycle.
module sweep_counter #(
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [AW-1:0] o_count,
  output logic          o_last_c
);

  logic [AW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + AW'(1);
    end
  end

  assign o_count  = r_count;
  assign o_last_c = (r_count == {AW{1'b1}});

endmodule

// File: rtl/mem_sequencer.sv
// Front-panel controller for the scratch memory: single-step write/read with
// address auto-increment, plus full-memory CLEAR and SUM (checksum) sweeps.
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  input  logic [1:0]    cmd,
  input  logic [DW-1:0] sw_data,
  input  logic          addr_load,
  input  logic [AW-1:0] sw_addr,
  input  logic [DW-1:0] mem_dout,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_write,
  output logic          mem_step,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] rd_data,
  output logic [DW-1:0] checksum,
  output logic          busy,
  output logic          done
);

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_acc;
  logic [DW-1:0] r_rd_data;
  logic [DW-1:0] r_checksum;
  logic          r_busy;
  logic          r_done;
  logic          r_mem_write;
  logic          r_mem_step;

  logic          w_sweeping;
  logic [AW-1:0] w_sweep;
  logic          w_sweep_last;

  assign w_sweeping = (r_state == ST_CLEAR) || (r_state == ST_SUM);

  // Counter is held at zero whenever no sweep runs, so every sweep starts at 0.
  sweep_counter #(.AW(AW)) u_sweep (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (~w_sweeping),
    .i_en     (w_sweeping),
    .o_count  (w_sweep),
    .o_last_c (w_sweep_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_acc       <= '0;
      r_rd_data   <= '0;
      r_checksum  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_step  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A load wins over a coincident step; that step is dropped.
          if (addr_load) begin
            r_addr <= sw_addr;
          end else if (step) begin
            r_busy <= 1'b1;
            case (cmd)
              CMD_WRITE: begin
                r_state     <= ST_WRITE;
                r_mem_write <= 1'b1;
                r_mem_step  <= 1'b1;
              end
              CMD_READ: begin
                r_state <= ST_READ;
              end
              CMD_CLEAR: begin
                r_state     <= ST_CLEAR;
                r_mem_write <= 1'b1;
                r_mem_step  <= 1'b1;
              end
              CMD_SUM: begin
                r_state <= ST_SUM;
                r_acc   <= '0;
              end
            endcase
          end
        end
        ST_WRITE: begin
          r_addr      <= r_addr + AW'(1);
          r_mem_write <= 1'b0;
          r_mem_step  <= 1'b0;
          r_done      <= 1'b1;
          r_state     <= ST_FIN;
        end
        ST_READ: begin
          r_rd_data <= mem_dout;
          r_addr    <= r_addr + AW'(1);
          r_done    <= 1'b1;
          r_state   <= ST_FIN;
        end
        ST_CLEAR: begin
          if (w_sweep_last) begin
            r_mem_write <= 1'b0;
            r_mem_step  <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= ST_FIN;
          end
        end
        ST_SUM: begin
          r_acc <= r_acc + mem_dout;
          if (w_sweep_last) begin
            r_checksum <= r_acc + mem_dout;
            r_done     <= 1'b1;
            r_state    <= ST_FIN;
          end
        end
        ST_FIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy      <= 1'b0;
          r_mem_write <= 1'b0;
          r_mem_step  <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = w_sweeping ? w_sweep : r_addr;
  assign mem_din   = (r_state == ST_WRITE) ? sw_data : '0;
  assign mem_write = r_mem_write;
  assign mem_step  = r_mem_step;
  assign addr      = r_addr;
  assign rd_data   = r_rd_data;
  assign checksum  = r_checksum;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed and randomized checks of mem_sequencer against an array-level
// reference model of the front panel and the 64x16 scratch memory.
module tb_mem_sequencer;

  localparam logic [1:0] C_WR  = 2'b00;
  localparam logic [1:0] C_RD  = 2'b01;
  localparam logic [1:0] C_CLR = 2'b10;
  localparam logic [1:0] C_SUM = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        step = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic [15:0] sw_data = '0;
  logic        addr_load = 1'b0;
  logic [5:0]  sw_addr = '0;
  logic [15:0] mem_dout;
  logic [5:0]  mem_addr;
  logic [15:0] mem_din;
  logic        mem_write;
  logic        mem_step;
  logic [5:0]  addr;
  logic [15:0] rd_data;
  logic [15:0] checksum;
  logic        busy;
  logic        done;

  // Scratch memory with a bench-side backdoor port for preloading.
  logic [15:0] mem [64];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_addr = '0;
  logic [15:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_write && mem_step) mem[mem_addr] <= mem_din;
  end
  assign mem_dout = mem[mem_addr];

  always #5 clk = ~clk;

  mem_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .cmd       (cmd),
    .sw_data   (sw_data),
    .addr_load (addr_load),
    .sw_addr   (sw_addr),
    .mem_dout  (mem_dout),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_write (mem_write),
    .mem_step  (mem_step),
    .addr      (addr),
    .rd_data   (rd_data),
    .checksum  (checksum),
    .busy      (busy),
    .done      (done)
  );

  int n_cmp = 0;
  int n_err = 0;
  int done_total = 0;

  logic [15:0] ref_mem [64];
  logic [5:0]  ref_addr = '0;
  logic [15:0] ref_rd = '0;
  logic [15:0] ref_chk = '0;

  always @(negedge clk) if (done) done_total++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_sum();
    int unsigned s = 0;
    for (int i = 0; i < 64; i++) s += 32'(ref_mem[i]);
    return 16'(s);
  endfunction

  task automatic check_mem(input string tag);
    for (int i = 0; i < 64; i++) check(tag, {16'h0, mem[i]}, {16'h0, ref_mem[i]});
  endtask

  task automatic bd_fill(input logic rnd, input logic [15:0] val);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      bd_we   = 1'b1;
      bd_addr = 6'(i);
      bd_data = rnd ? 16'($urandom) : val;
      ref_mem[i] = bd_data;
    end
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic do_load(input logic [5:0] a);
    @(negedge clk);
    addr_load = 1'b1;
    sw_addr   = a;
    @(negedge clk);
    addr_load = 1'b0;
    ref_addr  = a;
    check("load_addr", 32'(addr), 32'(ref_addr));
  endtask

  // Issue one command, wait for it to finish, then compare against the model.
  task automatic exec(input logic [1:0] c, input logic [15:0] d);
    int bc, dn, guard;
    @(negedge clk);
    step = 1'b1; cmd = c; sw_data = d;
    @(negedge clk);
    step = 1'b0;
    bc = 0; dn = 0; guard = 0;
    while (busy && guard < 200) begin
      bc++;
      if (done) dn++;
      guard++;
      @(negedge clk);
    end
    case (c)
      C_WR: begin ref_mem[ref_addr] = d; ref_addr = ref_addr + 6'd1; end
      C_RD: begin ref_rd = ref_mem[ref_addr]; ref_addr = ref_addr + 6'd1; end
      C_CLR: for (int i = 0; i < 64; i++) ref_mem[i] = '0;
      default: ref_chk = ref_sum();
    endcase
    check("exec_idle", 32'(busy), 32'd0);
    check("busy_cycles", 32'(bc), (c == C_WR || c == C_RD) ? 32'd2 : 32'd65);
    check("done_pulses", 32'(dn), 32'd1);
    check("addr", 32'(addr), 32'(ref_addr));
    check("rd_data", 32'(rd_data), 32'(ref_rd));
    check("checksum", 32'(checksum), 32'(ref_chk));
  endtask

  initial begin
    int d0, cyc;
    logic [15:0] pre [64];

    // Reset values
    bd_fill(1'b1, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    check("rst_chk", 32'(checksum), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr", 32'({mem_write, mem_step}), 32'd0);

    // Write then read back
    d0 = done_total;
    do_load(6'd5);
    exec(C_WR, 16'hBEEF);
    check("wr_mem5", 32'(mem[5]), 32'h0000BEEF);
    do_load(6'd5);
    exec(C_RD, 16'h0000);
    check("rd_beef", 32'(rd_data), 32'h0000BEEF);
    check("rd_addr6", 32'(addr), 32'd6);
    check("two_dones", 32'(done_total - d0), 32'd2);

    // Address wrap
    do_load(6'd63);
    exec(C_WR, 16'h1234);
    check("wrap_mem63", 32'(mem[63]), 32'h00001234);
    check("wrap_addr0", 32'(addr), 32'd0);
    exec(C_RD, 16'h0);

    // Preload i+1, SUM, CLEAR, SUM
    do_load(6'd0);
    for (int i = 0; i < 64; i++) exec(C_WR, 16'(i + 1));
    exec(C_SUM, 16'h0);
    check("sum_1_64", 32'(checksum), 32'h00000820);
    do_load(6'd17);
    exec(C_CLR, 16'hFFFF);
    check("clr_addr", 32'(addr), 32'd17);
    check_mem("clr_mem");
    exec(C_SUM, 16'h0);
    check("sum_zero", 32'(checksum), 32'd0);

    // Overflow: 63 x 0x400, then 64 x 0x400 wraps to 0
    do_load(6'd0);
    for (int i = 0; i < 63; i++) exec(C_WR, 16'h0400);
    exec(C_SUM, 16'h0);
    check("sum_fc00", 32'(checksum), 32'h0000FC00);
    exec(C_WR, 16'h0400);
    exec(C_SUM, 16'h0);
    check("sum_ovf", 32'(checksum), 32'd0);

    // Step during a CLEAR sweep is ignored
    d0 = done_total;
    @(negedge clk);
    step = 1'b1; cmd = C_CLR;
    @(negedge clk);
    step = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      if (cyc == 10) begin step = 1'b1; cmd = C_WR; sw_data = 16'hFFFF; end
      else step = 1'b0;
      @(negedge clk);
    end
    step = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    check("coll_busy", 32'(cyc), 32'd65);
    check("coll_dones", 32'(done_total - d0), 32'd1);
    check("coll_addr", 32'(addr), 32'(ref_addr));
    repeat (3) @(negedge clk);
    check("coll_idle", 32'(busy), 32'd0);
    check_mem("coll_mem");

    // addr_load and step in the same cycle: load only
    d0 = done_total;
    @(negedge clk);
    addr_load = 1'b1; sw_addr = 6'd42; step = 1'b1; cmd = C_WR; sw_data = 16'hAAAA;
    @(negedge clk);
    addr_load = 1'b0; step = 1'b0;
    ref_addr = 6'd42;
    check("ld_step_busy", 32'(busy), 32'd0);
    check("ld_step_addr", 32'(addr), 32'd42);
    repeat (3) @(negedge clk);
    check("ld_step_done", 32'(done_total - d0), 32'd0);
    check("ld_step_mem", 32'(mem[42]), 32'd0);

    // Async reset at sweep=20 of CLEAR
    bd_fill(1'b1, 16'h0);
    exec(C_SUM, 16'h0);
    do_load(6'd9);
    for (int i = 0; i < 64; i++) pre[i] = ref_mem[i];
    @(negedge clk);
    step = 1'b1; cmd = C_CLR;
    @(negedge clk);
    step = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_wr", 32'(mem_write), 32'd1);
    check("mid_sweep", 32'(mem_addr), 32'd20);
    reset = 1'b1;
    #1;
    check("arst_wr", 32'({mem_write, mem_step}), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_addr", 32'(addr), 32'd0);
    check("arst_chk", 32'(checksum), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = (i < 20) ? 16'h0 : pre[i];
    ref_addr = '0; ref_rd = '0; ref_chk = '0;
    check_mem("arst_mem");

    // Randomized command stream
    for (int k = 0; k < 80; k++) begin
      int r;
      logic [1:0] c;
      r = int'($urandom_range(0, 9));
      c = (r < 4) ? C_WR : (r < 8) ? C_RD : (r == 8) ? C_CLR : C_SUM;
      if ($urandom_range(0, 3) == 0) do_load(6'($urandom));
      exec(c, 16'($urandom));
    end
    check_mem("rand_mem");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
